// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
// State encoding, BCD digit width and per-digit modulus values.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LAP    = 2'd2,
    PAUSED = 2'd3
  } sw_state_e;

  localparam int BCD_W   = 4;
  localparam int MOD_TEN = 10;
  localparam int MOD_SIX = 6;
  localparam int N_DIG   = 6;

endpackage

// File: rtl/stopwatch_controller_digit.sv
// One BCD digit of the time chain with a fixed step per increment.
// Ports: clk, reset_n (sync, low), clr, inc, q (digit), carry (would roll).
module bcd_digit_counter #(
  parameter int MODULUS = 10,
  parameter int STEP    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  localparam logic [4:0] MOD5 = 5'(MODULUS);
  localparam logic [4:0] STP5 = 5'(STEP);

  logic [4:0] sum;

  assign sum = {1'b0, q} + STP5;

  // carry reports that the next increment would roll this digit over;
  // it does not depend on inc, so the parent can look ahead without a loop
  assign carry = (sum >= MOD5);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= carry ? 4'(sum - MOD5) : sum[3:0];
    end
  end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM and MM:SS.cc BCD counter with lap freeze.
// Ports: CLK_50MHz, reset_n, tick_100hz, two button pulses; status + 6 digits.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int SATURATE    = 0,
  parameter int CS_PER_TICK = 1
) (
  input  logic       CLK_50MHz,
  input  logic       reset_n,
  input  logic       tick_100hz,
  input  logic       btn_start_stop,
  input  logic       btn_lap_clear,
  output logic       running,
  output logic       lap_active,
  output logic       overflow,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] cs_ones
);

  localparam logic SAT = (SATURATE != 0);

  sw_state_e state_q, state_d;

  logic [N_DIG-1:0]            wrap;
  logic [N_DIG-1:0]            en;
  logic [N_DIG-1:0][BCD_W-1:0] live;
  logic [N_DIG-1:0][BCD_W-1:0] lap_q;
  logic [N_DIG-1:0][BCD_W-1:0] disp;

  logic ss, lc, adv, hit, sat_hit, en0;
  logic clr_cnt, lap_load;

  // start_stop has priority over lap_clear
  assign ss = btn_start_stop;
  assign lc = btn_lap_clear & ~btn_start_stop;

  assign adv     = tick_100hz &
                   ((state_q == RUN) | (state_q == LAP));
  // every digit at its last value: this tick leaves 59:59.99
  assign hit     = adv & (&wrap);
  assign sat_hit = SAT & hit;
  assign en0     = adv & ~sat_hit;

  for (genvar i = 0; i < N_DIG; i++) begin : g_dig
    localparam int MOD = (i == 3 || i == 5) ? MOD_SIX : MOD_TEN;
    localparam int STP = (i == 0) ? CS_PER_TICK : 1;

    if (i == 0) begin : g_en0
      assign en[i] = en0;
    end else begin : g_enn
      assign en[i] = en0 & (&wrap[i-1:0]);
    end

    bcd_digit_counter #(
      .MODULUS(MOD),
      .STEP   (STP)
    ) u_dig (
      .clk    (CLK_50MHz),
      .reset_n(reset_n),
      .clr    (clr_cnt),
      .inc    (en[i]),
      .q      (live[i]),
      .carry  (wrap[i])
    );
  end

  always_ff @(posedge CLK_50MHz) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ss) state_d = RUN;
      end
      RUN: begin
        if (ss)      state_d = PAUSED;
        else if (lc) state_d = LAP;
      end
      LAP: begin
        if (ss)      state_d = PAUSED;
        else if (lc) state_d = RUN;
      end
      PAUSED: begin
        if (ss)      state_d = RUN;
        else if (lc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (sat_hit) state_d = PAUSED;
  end

  always_comb begin
    running    = 1'b0;
    lap_active = 1'b0;
    unique case (state_q)
      RUN: running = 1'b1;
      LAP: begin
        running    = 1'b1;
        lap_active = 1'b1;
      end
      default: ;
    endcase
  end

  assign clr_cnt  = (state_q == PAUSED) & lc;
  assign lap_load = (state_q == RUN) & (state_d == LAP);

  always_ff @(posedge CLK_50MHz) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (clr_cnt) begin
      overflow <= 1'b0;
    end else if (hit) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK_50MHz) begin
    if (!reset_n) begin
      lap_q <= '0;
    end else if (lap_load) begin
      lap_q <= live;
    end
  end

  assign disp = lap_active ? lap_q : live;

  assign cs_ones  = disp[0];
  assign cs_tens  = disp[1];
  assign sec_ones = disp[2];
  assign sec_tens = disp[3];
  assign min_ones = disp[4];
  assign min_tens = disp[5];

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
Control FSM and BCD time counter for the stopwatch. It consumes the 100 Hz tick produced by the clock divider as a single-cycle enable in the CLK_50MHz domain and sequences start/stop, lap-freeze and clear from two debounced buttons. It drives six BCD digits (MM:SS.cc) to the seven-segment display stage. It also drives status flags.

Parameters:
SATURATE, 0, 0 = wrap 59:59.99 -> 00:00.00 and set overflow; 1 = hold at 59:59.99 and force PAUSED
CS_PER_TICK, 1, centisecond increment per tick (1..9); must be 1 in the shipped build, >1 only for accelerated sim

Ports:
CLK_50MHz  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset, sampled on CLK_50MHz rising edge
tick_100hz  input  1  one-CLK_50MHz-cycle pulse at 100 Hz from the clock divider
btn_start_stop  input  1  debounced single-cycle pulse
btn_lap_clear  input  1  debounced single-cycle pulse
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP (display frozen)
overflow  output  1  sticky, set on wrap/saturation, cleared by reset or clear
min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones  output  4 each  BCD display digits

Behaviour:
- Reset: the clock and reset are fixed as one clock, CLK_50MHz, with synchronous active-low reset reset_n. While reset_n = 0 at a rising edge, the block enters IDLE, zeroes the count and lap registers, and clears overflow. All outputs are then 0. Reset mid-run aborts immediately, with no partial update.
- States: IDLE, RUN, LAP, PAUSED. 2-bit encoding from the package.
- Transitions (current state, event in same cycle):
  - IDLE: start_stop -> RUN. lap_clear is ignored.
  - RUN: start_stop -> PAUSED. lap_clear -> LAP, and the live count is copied into the lap register on that edge.
  - LAP: lap_clear -> RUN, and the display returns to live. start_stop -> PAUSED, and the display shows live count.
  - PAUSED: start_stop -> RUN. lap_clear -> IDLE, zeroing the count and clearing overflow.
- Both buttons in the same cycle: start_stop wins and lap_clear is dropped.
- Counting: the count advances on an edge where tick_100hz = 1 and the current state is RUN or LAP. The decision uses the pre-transition state.
  - A tick coincident with stop in RUN is counted.
  - A tick coincident with start in IDLE or PAUSED is not counted.
- Digit chain: cs_ones 0-9, cs_tens 0-9, sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-5. Each digit carries into the next on rollover.
  - With CS_PER_TICK > 1, the cs add carries modulo 100.
  - Digits never hold a non-BCD value.
- Terminal value 59:59.99 with a tick applied:
  - SATURATE=0: all digits go to 0 and overflow is set on that edge. The state is unchanged.
  - SATURATE=1: digits hold, overflow is set, and the state goes to PAUSED. A later start resumes to RUN, and further ticks keep it saturated.
- Display: the digit outputs are a mux of lap register (LAP) vs live count (otherwise). A change is visible in the cycle after the causing edge, with no further latency.
- running and lap_active are decoded from the state register, so they are registered outputs.
- tick_100hz is held high for multiple cycles only in sim. The block counts one increment per high cycle and does no edge detection.

Decomposition:
- Package stopwatch_pkg contains:
  - state encodings IDLE=0, RUN=1, LAP=2, PAUSED=3
  - BCD width 4
  - per-digit modulus constants 10 and 6
- Sub-module bcd_digit_counter:
  - parameter MODULUS
  - ports: clk, reset_n, clr, inc, q[3:0], carry
  - instantiated 6 times in a ripple-enable chain
  - the cs_ones stage takes the CS_PER_TICK add

Test Plan:
- Reset: reset_n=0 for 2 edges mid-RUN at 00:03.27 -> all digits 0, running=0, lap_active=0, overflow=0 on the next cycle.
- Basic run: start pulse, then 150 ticks -> 00:01.50, running=1. Stop, then 20 ticks -> still 00:01.50, running=0.
- Lap: start, 100 ticks, lap_clear -> display frozen 00:01.00, lap_active=1. 50 more ticks -> still 00:01.00. lap_clear -> display 00:01.50, lap_active=0.
- Clear and priority: in PAUSED, pulse both buttons plus tick in one cycle -> RUN, count unchanged that edge. Stop, then lap_clear -> IDLE, all zeros.
- Rollover, SATURATE=0: run 360000 ticks (tick every cycle) -> 00:00.00, overflow=1, running=1. Check at 59 s -> sec 5/9 then 1:00.00.
- Saturation, SATURATE=1: 360001 ticks -> holds 59:59.99, overflow=1, state PAUSED, running=0. start, then 5 ticks -> still 59:59.99.
